mux_sched: RTL and testbench
============================

# mux_sched

Round-robin scheduler that shares one 1-bit select-driven 4-to-1 datapath (the `comb_str2`-style mux) among `NREQ` requesters. It arbitrates requests, drives the one-hot grant and the binary select index, and registers the selected data bit with a valid flag. It sits between the requesting agents and the shared combinational mux. It also bounds how long any one requester can occupy the mux.

## Interface
Parameters:
- `NREQ`, 4, number of requesters; fixed to 4 in this revision.
- `MAX_HOLD`, 8, maximum consecutive grant cycles before a forced rotation; legal range 1..255.

Ports:
- `clk` input 1: the block's single clock; all logic is rising-edge.
- `rst` input 1: reset, synchronous, active-high.
- `req` input `NREQ`: per-requester request, level-sensitive.
- `data` input `NREQ`: per-requester data bit; corresponds to A..D of the mux.
- `gnt` output `NREQ`: one-hot grant, registered.
- `sel` output 2: binary index of the granted requester, registered.
- `y` output 1: registered selected data bit.
- `y_valid` output 1: `y` carries a granted requester's data.
- `busy` output 1: high while any grant is active.

## Operation
- States: IDLE (`gnt`=0) and GRANT (exactly one `gnt` bit set).
- Winner selection: the first pending `req` searching upward from `last`+1 modulo `NREQ`.
  - `last` is the index of the most recent grant.
  - `last` updates to the winner on every new grant.
- IDLE to GRANT: any `req` bit is high at edge t. Then at t+1:
  - `gnt` is the winner, one-hot.
  - `sel` is the winner's index.
  - `busy`=1.
  - The hold counter is 1.
- GRANT, `req[sel]` still high, counter < `MAX_HOLD`: the grant is kept and the counter increments.
- GRANT, `req[sel]` drops at edge t:
  - If other requests are pending, the next winner is granted at t+1 with no idle gap.
  - Otherwise the block returns to IDLE at t+1, with `gnt`=0 and `busy`=0.
- GRANT, counter = `MAX_HOLD` and another `req` pending: forced rotation to the next winner at the next edge. The preempted requester is not eligible in that selection.
- GRANT, counter = `MAX_HOLD` and no other `req`: the grant is kept and the counter saturates at `MAX_HOLD`.
- Datapath, every edge:
  - `y` <= `data[sel]` when a grant is active, else 0.
  - `y_valid` <= `busy` & `req[sel]`.
- Simultaneous rise of several `req` bits from IDLE: the round-robin order from `last`+1 decides.
- Reset values: `gnt`=0, `sel`=0, `y`=0, `y_valid`=0, `busy`=0, hold counter=0, `last`=`NREQ`-1 (so requester 0 wins first).
- `rst` high mid-grant: all state returns to the reset values at that edge, with no partial release cycle. `rst` dominates `req`.

## Timing
- Request to grant latency: 1 cycle.
- Release to re-grant latency: 1 cycle.
- `data` to `y` latency: 1 cycle, through the registered `sel` path.
- Maximum wait for a continuously requesting input is (`NREQ`-1)×`MAX_HOLD` cycles, plus 1 cycle of grant latency.
- No combinational path from `req` or `data` to any output.

## Configuration
- `MUX_SCHED_RR_EN` defined: round-robin selection as described above.
- `MUX_SCHED_RR_EN` undefined: fixed priority, lowest index first.
  - Selection ignores `last`.
  - `MAX_HOLD` preemption still applies. The preempted index is excluded for exactly one selection, then the fixed-priority order resumes.

## Structure
- Package `mux_sched_pkg`:
  - state enum (`S_IDLE`, `S_GRANT`);
  - `NREQ_DEF`=4;
  - `SEL_W`=2;
  - hold counter width `HOLD_W`=8.
- One sub-module, `rr_pick`: combinational picker.
  - Inputs: pending mask, base index, exclude mask.
  - Outputs: one-hot winner, index, found flag.
- The top level holds the FSM, hold counter, `last` register and output registers.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with `req`=1111. Then `gnt`=0000, `sel`=0, `y`=0, `y_valid`=0, `busy`=0 throughout.
- Single requester: `req`=0100 with `data[2]` toggling 0,1,0,1.
  - One cycle after `req`, `gnt`=0100 and `sel`=2.
  - `y` follows `data[2]` delayed 1 cycle, with `y_valid`=1.
- Rotation: `req`=1111 held 40 cycles, `MAX_HOLD`=8. The grant sequence is 0,1,2,3,0, each lasting exactly 8 cycles with no idle gap.
- Early release: `req[1]` granted with `req[3]` pending; drop `req[1]` at cycle t. At t+1, `gnt`=1000 and `sel`=3.
- Saturation: `req`=0001 held 20 cycles. `gnt`=0001 is kept throughout and the hold counter sticks at 8.
- Reset mid-grant: assert `rst` during a grant of index 2. At the next edge all outputs are 0. Release `rst` with `req`=1111: requester 0 is granted first.
- Without `MUX_SCHED_RR_EN`: `req`=1010 held. Grants alternate index 1 for 8 cycles, then index 3 for 1 selection, then index 1 again.

Source files
------------

// File: rtl/mux_sched_pkg.sv
// mux_sched_pkg: shared types and widths for the round-robin mux scheduler
package mux_sched_pkg;
  typedef enum logic {S_IDLE, S_GRANT} state_t;
  localparam int NREQ_DEF = 4;
  localparam int SEL_W = 2;
  localparam int HOLD_W = 8;
endpackage

// File: rtl/mux_sched_if.sv
// mux_sched_if: requester-side request/data bundle and scheduler grant/result signals
interface mux_sched_if import mux_sched_pkg::*; #(parameter int NREQ = NREQ_DEF);
  logic [NREQ-1:0] req, data, gnt;
  logic [SEL_W-1:0] sel;
  logic y, y_valid, busy;
  modport master(output req, data, input gnt, sel, y, y_valid, busy);
  modport slave(input req, data, output gnt, sel, y, y_valid, busy);
endinterface

// File: rtl/mux_sched_rr_pick.sv
// rr_pick: first pending, non-excluded requester searching upward from base (wrapping)
module rr_pick import mux_sched_pkg::*; #(parameter int N = NREQ_DEF) (
  input  logic [N-1:0]     pend,
  input  logic [N-1:0]     excl,
  input  logic [SEL_W-1:0] base,
  output logic [N-1:0]     win,
  output logic [SEL_W-1:0] idx,
  output logic             found
);
  logic [N-1:0] m;
  logic [SEL_W-1:0] j;
  always_comb begin
    m = pend & ~excl;
    found = 1'b0;
    idx = '0;
    j = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = base + SEL_W'(i);
      if (m[j]) begin
        found = 1'b1;
        idx = j;
      end
    end
    win = found ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/mux_sched.sv
// mux_sched: round-robin (MUX_SCHED_RR_EN) or fixed-priority scheduler for a shared 4-to-1 mux
module mux_sched import mux_sched_pkg::*; #(
  parameter int NREQ = NREQ_DEF,
  parameter int MAX_HOLD = 8
) (
  input logic clk,
  input logic rst,
  mux_sched_if.slave bus
);
  state_t state;
  logic [HOLD_W-1:0] hold;
  logic [SEL_W-1:0] last, base, pick_idx;
  logic [NREQ-1:0] excl, pick_oh;
  logic found, hold_max, cur_req, keep;
  assign hold_max = hold == HOLD_W'(MAX_HOLD);
  assign cur_req = bus.req[bus.sel];
  assign keep = state == S_GRANT && cur_req && !hold_max;
  // in fixed-priority builds last never moves off NREQ-1, so the search always starts at 0
  assign base = last + 1'b1;
  assign excl = state == S_GRANT ? NREQ'(1) << bus.sel : '0;
  rr_pick #(.N(NREQ)) u_pick (
    .pend(bus.req), .excl(excl), .base(base),
    .win(pick_oh), .idx(pick_idx), .found(found)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      bus.gnt <= '0;
      bus.sel <= '0;
      bus.y <= 1'b0;
      bus.y_valid <= 1'b0;
      bus.busy <= 1'b0;
      hold <= '0;
      last <= SEL_W'(NREQ - 1);
    end else begin
      bus.y <= bus.busy & bus.data[bus.sel];
      bus.y_valid <= bus.busy & cur_req;
      if (keep) begin
        hold <= hold + 1'b1;
      end else if (found) begin
        state <= S_GRANT;
        bus.gnt <= pick_oh;
        bus.sel <= pick_idx;
        bus.busy <= 1'b1;
        hold <= HOLD_W'(1);
`ifdef MUX_SCHED_RR_EN
        last <= pick_idx;
`endif
      end else if (!(state == S_GRANT && cur_req)) begin
        state <= S_IDLE;
        bus.gnt <= '0;
        bus.busy <= 1'b0;
        hold <= '0;
      end
    end
  end
endmodule

// File: tb/tb_mux_sched.sv
// tb_mux_sched: directed self-checking bench for mux_sched
module tb_mux_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  mux_sched_if sif();
  mux_sched #(.NREQ(4), .MAX_HOLD(8)) dut (.clk(clk), .rst(rst), .bus(sif));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    sif.req = 4'b0000;
    sif.data = 4'b0000;
    step();
    rst = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    sif.req = 4'b1111;
    sif.data = 4'b1111;
    for (int c = 0; c < 2; c++) begin
      step();
      checks++;
      if ({sif.gnt, sif.sel, sif.y, sif.y_valid, sif.busy} !== 9'b0) begin
        errors++;
        $display("FAIL reset cyc%0d gnt=%b sel=%0d y=%b yv=%b busy=%b want all 0",
                 c, sif.gnt, sif.sel, sif.y, sif.y_valid, sif.busy);
      end
    end
    rst = 1'b0;
    sif.req = 4'b0000;
    step();
  endtask
  task automatic test_single();
    logic [3:0] pat;
    pat = 4'b1010;
    do_reset();
    sif.req = 4'b0100;
    step();
    checks++;
    if ({sif.gnt, sif.sel, sif.busy} !== {4'b0100, 2'd2, 1'b1}) begin
      errors++;
      $display("FAIL single_grant gnt=%b sel=%0d busy=%b want 0100/2/1", sif.gnt, sif.sel, sif.busy);
    end
    for (int k = 0; k < 4; k++) begin
      sif.data[2] = pat[k];
      step();
      checks++;
      if ({sif.y, sif.y_valid} !== {pat[k], 1'b1}) begin
        errors++;
        $display("FAIL single_data k=%0d y=%b yv=%b want %b/1", k, sif.y, sif.y_valid, pat[k]);
      end
    end
    sif.req = 4'b0000;
    step();
    checks++;
    if ({sif.gnt, sif.busy, sif.y_valid} !== 6'b0) begin
      errors++;
      $display("FAIL single_release gnt=%b busy=%b yv=%b want 0", sif.gnt, sif.busy, sif.y_valid);
    end
  endtask
  task automatic test_rotation();
    logic [1:0] e;
    do_reset();
    sif.req = 4'b1111;
    for (int k = 0; k < 40; k++) begin
      step();
`ifdef MUX_SCHED_RR_EN
      e = 2'((k / 8) % 4);
`else
      e = 2'((k / 8) % 2);
`endif
      checks++;
      if ({sif.gnt, sif.sel, sif.busy} !== {4'b0001 << e, e, 1'b1}) begin
        errors++;
        $display("FAIL rotation k=%0d gnt=%b sel=%0d busy=%b want sel=%0d", k, sif.gnt, sif.sel, sif.busy, e);
      end
    end
    sif.req = 4'b0000;
    step();
  endtask
  task automatic test_early_release();
    do_reset();
    sif.req = 4'b0010;
    step();
    sif.req = 4'b1010;
    step();
    checks++;
    if ({sif.gnt, sif.sel} !== {4'b0010, 2'd1}) begin
      errors++;
      $display("FAIL early_hold gnt=%b sel=%0d want 0010/1", sif.gnt, sif.sel);
    end
    sif.req = 4'b1000;
    step();
    checks++;
    if ({sif.gnt, sif.sel, sif.busy} !== {4'b1000, 2'd3, 1'b1}) begin
      errors++;
      $display("FAIL early_regrant gnt=%b sel=%0d busy=%b want 1000/3/1", sif.gnt, sif.sel, sif.busy);
    end
    sif.req = 4'b0000;
    step();
  endtask
  task automatic test_saturation();
    do_reset();
    sif.req = 4'b0001;
    for (int k = 0; k < 20; k++) begin
      step();
      checks++;
      if (sif.gnt !== 4'b0001) begin
        errors++;
        $display("FAIL saturation k=%0d gnt=%b want 0001", k, sif.gnt);
      end
    end
    checks++;
    if (dut.hold !== 8'd8) begin
      errors++;
      $display("FAIL saturation_hold hold=%0d want 8", dut.hold);
    end
    sif.req = 4'b0000;
    step();
  endtask
  task automatic test_reset_mid();
    do_reset();
    sif.req = 4'b0100;
    sif.data = 4'b0100;
    step();
    step();
    checks++;
    if ({sif.gnt, sif.y} !== {4'b0100, 1'b1}) begin
      errors++;
      $display("FAIL midrst_pre gnt=%b y=%b want 0100/1", sif.gnt, sif.y);
    end
    rst = 1'b1;
    sif.req = 4'b1111;
    step();
    checks++;
    if ({sif.gnt, sif.sel, sif.y, sif.y_valid, sif.busy} !== 9'b0) begin
      errors++;
      $display("FAIL midrst gnt=%b sel=%0d y=%b yv=%b busy=%b want all 0",
               sif.gnt, sif.sel, sif.y, sif.y_valid, sif.busy);
    end
    rst = 1'b0;
    step();
    checks++;
    if ({sif.gnt, sif.sel} !== {4'b0001, 2'd0}) begin
      errors++;
      $display("FAIL midrst_first gnt=%b sel=%0d want 0001/0", sif.gnt, sif.sel);
    end
    sif.req = 4'b0000;
    step();
  endtask
  task automatic test_back_to_back();
    logic [1:0] e;
    do_reset();
    sif.req = 4'b1010;
    for (int k = 0; k < 20; k++) begin
      step();
      e = (k / 8) % 2 == 1 ? 2'd3 : 2'd1;
      checks++;
      if ({sif.gnt, sif.sel} !== {4'b0001 << e, e}) begin
        errors++;
        $display("FAIL back_to_back k=%0d gnt=%b sel=%0d want sel=%0d", k, sif.gnt, sif.sel, e);
      end
    end
    sif.req = 4'b0000;
    step();
  endtask
  initial begin
    sif.req = 4'b0000;
    sif.data = 4'b0000;
    test_reset();
    test_single();
    test_rotation();
    test_early_release();
    test_saturation();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
